// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch-predictor update path.
// Counter encodings, sequencer states and the saturating update rule.
package bp_pkg;

   localparam int BP_INDEX_BITS = 4;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      CLEAR
   } state_e;

   function automatic logic [1:0] sat_next(
      input logic [1:0] ctr,
      input logic       taken
   );
      logic [1:0] r;
      r = ctr;
      if (taken) begin
         if (ctr != ST) r = ctr + 2'b01;
      end else begin
         if (ctr != SNT) r = ctr - 2'b01;
      end
      return r;
   endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Update FIFO: up to two pushes and one pop per cycle.
// Reports the number of free slots for the upstream arbiter.
module bp_update_fifo #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_a_en,
   input  logic [WIDTH-1:0] wr_a_data,
   input  logic             wr_b_en,
   input  logic [WIDTH-1:0] wr_b_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic [AW:0]      free
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp;
   logic [AW-1:0]    rp;
   logic [AW:0]      cnt;
   logic [AW:0]      n_wr;
   logic             rd;

   assign rd      = rd_en & (cnt != '0);
   assign n_wr    = (AW+1)'(wr_a_en) + (AW+1)'(wr_b_en);
   assign empty   = (cnt == '0);
   assign free    = (AW+1)'(DEPTH) - cnt;
   assign rd_data = mem[rp];

   // storage: slot b always follows slot a
   always_ff @(posedge clk) begin
      if (wr_a_en) mem[wp] <= wr_a_data;
      if (wr_b_en) mem[wp + AW'(1)] <= wr_b_data;
   end

   // pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         wp  <= wp + n_wr[AW-1:0];
         rp  <= rp + AW'(rd);
         cnt <= cnt + n_wr - (AW+1)'(rd);
      end
   end

endmodule

// File: rtl/bp_update_sequencer.sv
// Resolved-branch update sequencer: arbitration, FIFO, PHT read-modify-write.
// Optional clear sweep is built when BP_CLEAR_EN is defined.
module bp_update_sequencer
   import bp_pkg::*;
#(
   parameter int         INDEX_BITS = BP_INDEX_BITS,
   parameter int         TABLE_SIZE = 16,
   parameter int         FIFO_DEPTH = 4,
   parameter logic [1:0] CLEAR_VAL  = WNT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  up0_valid,
   input  logic [31:0]           up0_pc,
   input  logic                  up0_taken,
   output logic                  up0_ready,
   input  logic                  up1_valid,
   input  logic [31:0]           up1_pc,
   input  logic                  up1_taken,
   output logic                  up1_ready,
   input  logic                  clear_req,
   output logic                  clear_busy,
   output logic                  clear_done,
   output logic [INDEX_BITS-1:0] pht_rd_idx,
   input  logic [1:0]            pht_rd_data,
   output logic                  pht_wr_en,
   output logic [INDEX_BITS-1:0] pht_wr_idx,
   output logic [1:0]            pht_wr_data,
   output logic                  idle
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int DW = INDEX_BITS + 1;
   localparam logic [AW:0] ONE = (AW+1)'(1);
   localparam logic [AW:0] TWO = (AW+1)'(2);

   logic [AW:0]           free;
   logic                  empty;
   logic [DW-1:0]         head;
   logic [DW-1:0]         d0;
   logic [DW-1:0]         d1;
   logic [DW-1:0]         wa_data;
   logic [DW-1:0]         wb_data;
   logic                  acc0;
   logic                  acc1;
   logic                  rr;
   logic                  run;
   logic                  sweep;
   logic [INDEX_BITS-1:0] sweep_idx;
   logic [INDEX_BITS-1:0] r_idx;
   logic                  r_taken;
   logic [1:0]            r_old;
   logic                  w_valid;
   logic [INDEX_BITS-1:0] w_idx;
   logic                  w_taken;
   logic [1:0]            w_old;
   logic [1:0]            w_new;
   logic                  unused_ok;

   assign unused_ok = ^{clear_req, CLEAR_VAL,
                        up0_pc[31:INDEX_BITS+2], up0_pc[1:0],
                        up1_pc[31:INDEX_BITS+2], up1_pc[1:0],
                        TABLE_SIZE == (1 << INDEX_BITS)};

   // ready from free slots and rr only
   always_comb begin
      up0_ready = 1'b0;
      up1_ready = 1'b0;
      if (run) begin
         if (free >= TWO) begin
            up0_ready = 1'b1;
            up1_ready = 1'b1;
         end else if (free == ONE) begin
            up0_ready = ~rr;
            up1_ready = rr;
         end
      end
   end

   assign acc0 = up0_valid & up0_ready;
   assign acc1 = up1_valid & up1_ready;

   assign d0 = {up0_taken, up0_pc[INDEX_BITS+1:2]};
   assign d1 = {up1_taken, up1_pc[INDEX_BITS+1:2]};

   assign wa_data = (acc0 & acc1) ? (rr ? d1 : d0)
                                  : (acc0 ? d0 : d1);
   assign wb_data = rr ? d0 : d1;

   // rr flips after every dual-valid cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rr <= 1'b0;
      else if (up0_valid & up1_valid) rr <= ~rr;
   end

   bp_update_fifo #(
      .WIDTH (DW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_a_en   (acc0 | acc1),
      .wr_a_data (wa_data),
      .wr_b_en   (acc0 & acc1),
      .wr_b_data (wb_data),
      .rd_en     (~empty),
      .rd_data   (head),
      .empty     (empty),
      .free      (free)
   );

   assign r_idx      = head[INDEX_BITS-1:0];
   assign r_taken    = head[INDEX_BITS];
   assign pht_rd_idx = empty ? '0 : r_idx;
   assign w_new      = sat_next(w_old, w_taken);
   assign r_old      = (w_valid && (w_idx == r_idx)) ? w_new : pht_rd_data;

   // W stage: capture the popped update and its old counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_valid <= 1'b0;
         w_idx   <= '0;
         w_taken <= 1'b0;
         w_old   <= 2'b00;
      end else begin
         w_valid <= ~empty;
         if (!empty) begin
            w_idx   <= r_idx;
            w_taken <= r_taken;
            w_old   <= r_old;
         end
      end
   end

`ifdef BP_CLEAR_EN
   localparam logic [INDEX_BITS-1:0] LAST = INDEX_BITS'(TABLE_SIZE - 1);

   state_e                state;
   logic [INDEX_BITS-1:0] clr_idx;

   // drain the FIFO, then sweep the table once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= CLEAR;
         clr_idx    <= '0;
         clear_busy <= 1'b1;
         clear_done <= 1'b0;
      end else begin
         unique case (state)
            RUN: begin
               if (clear_req) begin
                  state      <= DRAIN;
                  clear_busy <= 1'b1;
               end
            end
            DRAIN: begin
               if (empty) begin
                  state   <= CLEAR;
                  clr_idx <= '0;
               end
            end
            CLEAR: begin
               if (clr_idx == LAST) begin
                  state      <= RUN;
                  clear_busy <= 1'b0;
                  clear_done <= 1'b0;
               end else begin
                  clr_idx    <= clr_idx + 1'b1;
                  clear_done <= (clr_idx + 1'b1) == LAST;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   assign run       = (state == RUN);
   assign sweep     = (state == CLEAR);
   assign sweep_idx = clr_idx;
`else
   assign run        = 1'b1;
   assign sweep      = 1'b0;
   assign sweep_idx  = '0;
   assign clear_busy = 1'b0;
   assign clear_done = 1'b0;
`endif

   assign pht_wr_en   = w_valid | sweep;
   assign pht_wr_idx  = w_valid ? w_idx : (sweep ? sweep_idx : '0);
   assign pht_wr_data = w_valid ? w_new : (sweep ? CLEAR_VAL : 2'b00);
   assign idle        = empty & ~w_valid & run;

endmodule

// File: tb/tb_bp_update_sequencer.sv
// Bench for bp_update_sequencer: directed steps plus random traffic.
// Reference model applies updates in acceptance order to a shadow table.
module tb_bp_update_sequencer;

   typedef struct packed {
      logic [3:0] idx;
      logic       taken;
   } upd_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        up0_valid = 1'b0;
   logic [31:0] up0_pc = '0;
   logic        up0_taken = 1'b0;
   logic        up0_ready;
   logic        up1_valid = 1'b0;
   logic [31:0] up1_pc = '0;
   logic        up1_taken = 1'b0;
   logic        up1_ready;
   logic        clear_req = 1'b0;
   logic        clear_busy;
   logic        clear_done;
   logic [3:0]  pht_rd_idx;
   logic [1:0]  pht_rd_data;
   logic        pht_wr_en;
   logic [3:0]  pht_wr_idx;
   logic [1:0]  pht_wr_data;
   logic        idle;

   logic [1:0]  pht [16];
   logic [1:0]  model_pht [16];
   upd_t        expq [$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          mcnt = 0;
   int          sw_cnt = 0;
   bit          mrr = 1'b0;
   logic        tb_we = 1'b0;
   logic [3:0]  tb_idx = '0;
   logic [1:0]  tb_val = '0;

   bp_update_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .up0_valid   (up0_valid),
      .up0_pc      (up0_pc),
      .up0_taken   (up0_taken),
      .up0_ready   (up0_ready),
      .up1_valid   (up1_valid),
      .up1_pc      (up1_pc),
      .up1_taken   (up1_taken),
      .up1_ready   (up1_ready),
      .clear_req   (clear_req),
      .clear_busy  (clear_busy),
      .clear_done  (clear_done),
      .pht_rd_idx  (pht_rd_idx),
      .pht_rd_data (pht_rd_data),
      .pht_wr_en   (pht_wr_en),
      .pht_wr_idx  (pht_wr_idx),
      .pht_wr_data (pht_wr_data),
      .idle        (idle)
   );

   always #5 clk = ~clk;

   assign pht_rd_data = pht[pht_rd_idx];

   always @(posedge clk) begin
      if (!rst) begin
         if (pht_wr_en) pht[pht_wr_idx] <= pht_wr_data;
         else if (tb_we) pht[tb_idx] <= tb_val;
      end
   end

   function automatic logic [1:0] ref_sat(input logic [1:0] c, input logic t);
      int v;
      v = int'(c) + (t ? 1 : -1);
      if (v > 3) v = 3;
      if (v < 0) v = 0;
      return 2'(v);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // every PHT write must be the next queued update or the next sweep entry
   always @(negedge clk) begin
      upd_t       u;
      logic [1:0] e;
      if (!rst && pht_wr_en) begin
         if (expq.size() > 0) begin
            u = expq.pop_front();
            e = ref_sat(model_pht[u.idx], u.taken);
            chk("wr_idx", 32'(pht_wr_idx), 32'(u.idx));
            chk("wr_data", 32'(pht_wr_data), 32'(e));
            model_pht[u.idx] = e;
         end else begin
`ifdef BP_CLEAR_EN
            chk("sweep_idx", 32'(pht_wr_idx), 32'(sw_cnt));
            chk("sweep_data", 32'(pht_wr_data), 32'h1);
            if (sw_cnt == 15) chk("sweep_done", 32'(clear_done), 32'h1);
            model_pht[pht_wr_idx] = 2'b01;
            sw_cnt++;
`else
            chk("spurious_wr", 32'(pht_wr_en), 32'h0);
`endif
         end
      end
   end

   task automatic step(input logic v0, input logic [31:0] p0, input logic t0,
                       input logic v1, input logic [31:0] p1, input logic t1,
                       input bit cr);
      int   fr;
      logic e0, e1, a0, a1;
      upd_t u0, u1;
      up0_valid = v0; up0_pc = p0; up0_taken = t0;
      up1_valid = v1; up1_pc = p1; up1_taken = t1;
      #1;
      if (cr) begin
         fr = 4 - mcnt;
         e0 = (fr >= 2) || (fr == 1 && !mrr);
         e1 = (fr >= 2) || (fr == 1 && mrr);
         chk("ready0", 32'(up0_ready), 32'(e0));
         chk("ready1", 32'(up1_ready), 32'(e1));
      end
      a0 = v0 & up0_ready;
      a1 = v1 & up1_ready;
      u0 = {p0[5:2], t0};
      u1 = {p1[5:2], t1};
      if (a0 && a1 && mrr) begin
         expq.push_back(u1);
         expq.push_back(u0);
      end else begin
         if (a0) expq.push_back(u0);
         if (a1) expq.push_back(u1);
      end
      mcnt = mcnt + int'(a0) + int'(a1) - ((mcnt > 0) ? 1 : 0);
      if (v0 && v1) mrr = !mrr;
      @(negedge clk); #1;
      up0_valid = 1'b0;
      up1_valid = 1'b0;
   endtask

   task automatic nop(input bit cr);
      step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, cr);
   endtask

   task automatic poke(input logic [3:0] i, input logic [1:0] v);
      tb_idx = i; tb_val = v; tb_we = 1'b1;
      nop(1'b1);
      tb_we = 1'b0;
      model_pht[i] = v;
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && !(idle === 1'b1 && expq.size() == 0); k++)
         nop(1'b1);
      chk("drain_idle", 32'(idle), 32'h1);
      chk("drain_q", 32'(expq.size()), 32'h0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      up0_valid = 1'b0; up1_valid = 1'b0;
      clear_req = 1'b0; tb_we = 1'b0;
      #2;
`ifdef BP_CLEAR_EN
      chk("rst_ready0", 32'(up0_ready), 32'h0);
      chk("rst_ready1", 32'(up1_ready), 32'h0);
      chk("rst_busy", 32'(clear_busy), 32'h1);
      chk("rst_idle", 32'(idle), 32'h0);
`else
      chk("rst_ready0", 32'(up0_ready), 32'h1);
      chk("rst_ready1", 32'(up1_ready), 32'h1);
      chk("rst_busy", 32'(clear_busy), 32'h0);
      chk("rst_idle", 32'(idle), 32'h1);
      chk("rst_wr_en", 32'(pht_wr_en), 32'h0);
`endif
      chk("rst_done", 32'(clear_done), 32'h0);
      chk("rst_rd_idx", 32'(pht_rd_idx), 32'h0);
      expq.delete();
      mcnt = 0; mrr = 1'b0; sw_cnt = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk); #1;
`ifdef BP_CLEAR_EN
      for (int k = 0; k < 40 && clear_busy; k++) nop(1'b0);
      chk("sweep_end_busy", 32'(clear_busy), 32'h0);
      chk("sweep_count", 32'(sw_cnt), 32'd16);
`endif
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      for (int i = 0; i < 16; i++) poke(4'(i), 2'($urandom_range(0, 3)));

      // single update, one step up from 01
      poke(4'd4, 2'b01);
      step(1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      chk("t1_rd_idx", 32'(pht_rd_idx), 32'h4);
      nop(1'b1);
      chk("t1_wr_en", 32'(pht_wr_en), 32'h1);
      chk("t1_wr_idx", 32'(pht_wr_idx), 32'h4);
      chk("t1_wr_data", 32'(pht_wr_data), 32'h2);
      nop(1'b1);
      chk("t1_pht4", 32'(pht[4]), 32'h2);

      // back-to-back same index uses the forwarded counter
      poke(4'd4, 2'b00);
      step(1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      step(1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      chk("fwd_wr1", 32'(pht_wr_data), 32'h1);
      nop(1'b1);
      chk("fwd_wr2", 32'(pht_wr_data), 32'h2);
      nop(1'b1);
      chk("fwd_pht4", 32'(pht[4]), 32'h2);

      // saturation at both ends
      poke(4'd7, 2'b11);
      poke(4'd9, 2'b00);
      step(1'b1, 32'h1C, 1'b1, 1'b1, 32'h24, 1'b0, 1'b1);
      drain();
      chk("sat_st", 32'(pht[7]), 32'h3);
      chk("sat_snt", 32'(pht[9]), 32'h0);

      // upper pc bits alias onto the same entry
      poke(4'd4, 2'b01);
      step(1'b1, 32'hABCD_0010, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      drain();
      chk("alias_pht4", 32'(pht[4]), 32'h2);

      // dual pipes for 8 cycles from an empty FIFO
      do_reset();
      step(1'b1, 32'h0, 1'b1, 1'b1, 32'h4, 1'b0, 1'b1);
      chk("dual_first_rd", 32'(pht_rd_idx), 32'h0);
      for (int i = 0; i < 7; i++)
         step(1'b1, 32'h0, 1'($urandom_range(0, 1)),
              1'b1, 32'h4, 1'($urandom_range(0, 1)), 1'b1);
      drain();

      // random traffic on both pipes
      for (int i = 0; i < 200; i++)
         step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)),
              1'b1);
      drain();
      for (int i = 0; i < 16; i++)
         chk($sformatf("table_%0d", i), 32'(pht[i]), 32'(model_pht[i]));

`ifdef BP_CLEAR_EN
      // clear with updates pending, then a reset in the middle of a sweep
      sw_cnt = 0;
      step(1'b1, 32'h8, 1'b1, 1'b1, 32'hC, 1'b0, 1'b1);
      clear_req = 1'b1;
      nop(1'b1);
      clear_req = 1'b0;
      nop(1'b0);
      chk("clr_ready0", 32'(up0_ready), 32'h0);
      chk("clr_busy", 32'(clear_busy), 32'h1);
      for (int k = 0; k < 40 && sw_cnt < 16; k++) nop(1'b0);
      chk("clr_count", 32'(sw_cnt), 32'd16);
      chk("clr_q", 32'(expq.size()), 32'h0);
      nop(1'b1);
      chk("clr_busy_end", 32'(clear_busy), 32'h0);
      sw_cnt = 0;
      clear_req = 1'b1;
      nop(1'b1);
      clear_req = 1'b0;
      for (int k = 0; k < 40 && sw_cnt < 5; k++) nop(1'b0);
      chk("mid_sweep", 32'(sw_cnt >= 5), 32'h1);
      do_reset();
`else
      clear_req = 1'b1;
      nop(1'b1);
      clear_req = 1'b0;
      nop(1'b1);
      chk("noclr_busy", 32'(clear_busy), 32'h0);
      chk("noclr_idle", 32'(idle), 32'h1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
